// File: rtl/dmaster_p2b_converter.sv
// Packets-to-bytes converter: expands Avalon-ST packet beats into an escaped byte stream.
// Define DMASTER_P2B_CHANNEL_EN to emit channel markers; otherwise in_channel is ignored.
//
// state     | meaning
// IDLE      | no byte pending, ready for a beat
// CHAN_MARK | presenting 0x7C
// CHAN_ESC  | presenting 0x7D ahead of a special channel number
// CHAN      | presenting channel number (escaped if special)
// SOP_MARK  | presenting 0x7A
// EOP_MARK  | presenting 0x7B
// DATA_ESC  | presenting 0x7D ahead of a special payload byte
// DATA      | presenting payload byte (escaped if special)
module dmaster_p2b_converter (
    input  logic       clk,
    input  logic       reset_n,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [7:0] in_channel,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHAN_MARK, S_CHAN_ESC, S_CHAN,
        S_SOP_MARK, S_EOP_MARK, S_DATA_ESC, S_DATA
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic [7:0] r_data;
    logic [7:0] r_chan;
    logic       r_sop;
    logic       r_eop;
    logic       w_accept;
    logic       w_adv;
    logic       w_need_chan;
    logic [7:0] w_sel_data;
    logic [7:0] w_sel_chan;
    logic [7:0] w_byte_nxt;

    function automatic logic f_special(input logic [7:0] b);
        return (b >= 8'h7A) && (b <= 8'h7D);
    endfunction

    function automatic state_t f_data_first(input logic [7:0] d);
        return f_special(d) ? S_DATA_ESC : S_DATA;
    endfunction

    function automatic state_t f_after_sop(input logic eop, input logic [7:0] d);
        return eop ? S_EOP_MARK : f_data_first(d);
    endfunction

    function automatic state_t f_after_chan(input logic sop, input logic eop, input logic [7:0] d);
        return sop ? S_SOP_MARK : f_after_sop(eop, d);
    endfunction

`ifdef DMASTER_P2B_CHANNEL_EN
    logic [7:0] r_last_chan;

    assign w_need_chan = in_startofpacket || (in_channel != r_last_chan);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last_chan <= 8'h00;
        else if (w_adv && (r_state == S_CHAN))
            r_last_chan <= r_chan;
    end
`else
    assign w_need_chan = 1'b0;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_adv    = r_out_valid && out_ready;

    // State register, output byte register and beat holding register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_data      <= 8'h00;
            r_chan      <= 8'h00;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_IDLE);
            r_out_data  <= w_byte_nxt;
            if (w_accept) begin
                r_data <= in_data;
                r_chan <= in_channel;
                r_sop  <= in_startofpacket;
                r_eop  <= in_endofpacket;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_need_chan ? S_CHAN_MARK
                        : f_after_chan(in_startofpacket, in_endofpacket, in_data);
        end else if (w_adv) begin
            case (r_state)
                S_CHAN_MARK: w_state_nxt = f_special(r_chan) ? S_CHAN_ESC : S_CHAN;
                S_CHAN_ESC:  w_state_nxt = S_CHAN;
                S_CHAN:      w_state_nxt = f_after_chan(r_sop, r_eop, r_data);
                S_SOP_MARK:  w_state_nxt = f_after_sop(r_eop, r_data);
                S_EOP_MARK:  w_state_nxt = f_data_first(r_data);
                S_DATA_ESC:  w_state_nxt = S_DATA;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The byte is computed for the state being entered so out_data is registered with it;
    // while stalled the state and holding register are unchanged, so the byte holds.
    always_comb begin
        in_ready   = (r_state == S_IDLE) || ((r_state == S_DATA) && out_ready);
        w_sel_data = w_accept ? in_data : r_data;
        w_sel_chan = w_accept ? in_channel : r_chan;
        w_byte_nxt = 8'h00;
        case (w_state_nxt)
            S_CHAN_MARK: w_byte_nxt = 8'h7C;
            S_CHAN_ESC:  w_byte_nxt = 8'h7D;
            S_CHAN:      w_byte_nxt = f_special(w_sel_chan) ? (w_sel_chan ^ 8'h20) : w_sel_chan;
            S_SOP_MARK:  w_byte_nxt = 8'h7A;
            S_EOP_MARK:  w_byte_nxt = 8'h7B;
            S_DATA_ESC:  w_byte_nxt = 8'h7D;
            S_DATA:      w_byte_nxt = f_special(w_sel_data) ? (w_sel_data ^ 8'h20) : w_sel_data;
            default:     w_byte_nxt = 8'h00;
        endcase
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_dmaster_p2b_converter.sv
// Self-checking bench for dmaster_p2b_converter; follows DMASTER_P2B_CHANNEL_EN like the design.
module tb_dmaster_p2b_converter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_channel = 8'h00;
    logic       in_startofpacket = 1'b0;
    logic       in_endofpacket = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_last_ch = 8'h00;

    dmaster_p2b_converter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= 8'h7A) && (b <= 8'h7D);
    endfunction

    // Reference expansion of one beat into the expected byte queue
    task automatic model_push(input logic [7:0] d, input logic [7:0] ch,
                              input logic sop, input logic eop, output int n);
        n = 0;
`ifdef DMASTER_P2B_CHANNEL_EN
        if (sop || (ch != m_last_ch)) begin
            exp_q.push_back(8'h7C); n++;
            if (is_special(ch)) begin
                exp_q.push_back(8'h7D); exp_q.push_back(ch ^ 8'h20); n += 2;
            end else begin
                exp_q.push_back(ch); n++;
            end
            m_last_ch = ch;
        end
`endif
        if (sop) begin exp_q.push_back(8'h7A); n++; end
        if (eop) begin exp_q.push_back(8'h7B); n++; end
        if (is_special(d)) begin
            exp_q.push_back(8'h7D); exp_q.push_back(d ^ 8'h20); n += 2;
        end else begin
            exp_q.push_back(d); n++;
        end
    endtask

    // Scoreboard: every transferred byte is popped and compared
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL stream_byte: got %02h, expected no byte (queue empty)", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_errors++;
                    $display("FAIL stream_byte: got %02h, expected %02h", out_data, e);
                end
            end
        end
    end

    // Presents a beat and holds it until accepted; returns cycles waited and bytes expected
    task automatic send_beat(input logic [7:0] d, input logic [7:0] ch, input logic sop,
                             input logic eop, output int waits, output int nbytes);
        logic rdy;
        logic acc;
        in_data = d; in_channel = ch; in_startofpacket = sop; in_endofpacket = eop;
        in_valid = 1'b1;
        waits = 0; nbytes = 0; acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else     waits++;
        end
        if (acc) model_push(d, ch, sop, eop, nbytes);
        else begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: beat %02h not accepted, expected acceptance", d);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) ok = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data: got %02h, expected 00", out_data); end
        if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_valid: got %b, expected 0", out_valid); end
    endtask

    task automatic test_sop_eop();
        int w, n;
        bit ok;
        out_ready = 1'b1;
        send_beat(8'h41, 8'h00, 1'b1, 1'b1, w, n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL sop_eop_valid[%0d]: got %b, expected 1", k, out_valid); end
            if (in_ready !== (k == n - 1)) begin
                n_errors++; $display("FAIL sop_eop_in_ready[%0d]: got %b, expected %b", k, in_ready, (k == n - 1));
            end
            @(posedge clk); #1;
        end
        wait_drain(ok);
        n_checks++;
        if (!ok || out_valid !== 1'b0) begin n_errors++; $display("FAIL sop_eop_drain: valid %b left %0d, expected idle", out_valid, exp_q.size()); end
    endtask

    task automatic test_midpacket();
        int w, n;
        bit ok;
        logic [7:0] d[3] = '{8'h10, 8'h11, 8'h12};
        for (int i = 0; i < 3; i++) begin
            send_beat(d[i], 8'h00, 1'b0, 1'b0, w, n);
            n_checks++;
            if (w !== 0) begin n_errors++; $display("FAIL midpacket_wait[%0d]: got %0d cycles, expected 0", i, w); end
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL midpacket_drain: %0d bytes left, expected 0", exp_q.size()); end
    endtask

    task automatic test_escape();
        int w, n;
        bit ok;
        send_beat(8'h7B, 8'h00, 1'b0, 1'b0, w, n);
        send_beat(8'h7D, 8'h00, 1'b0, 1'b0, w, n);
        n_checks++;
        if (w !== 1) begin n_errors++; $display("FAIL escape_wait: got %0d cycles, expected 1", w); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL escape_drain: %0d bytes left, expected 0", exp_q.size()); end
    endtask

    task automatic test_channel_switch();
        int w, n, exp_w;
        bit ok;
`ifdef DMASTER_P2B_CHANNEL_EN
        exp_w = 3;
`else
        exp_w = 0;
`endif
        send_beat(8'h55, 8'h7C, 1'b0, 1'b0, w, n);
        send_beat(8'h66, 8'h7C, 1'b0, 1'b0, w, n);
        n_checks++;
        if (w !== exp_w) begin n_errors++; $display("FAIL chan_switch_wait: got %0d cycles, expected %0d", w, exp_w); end
        send_beat(8'h77, 8'h00, 1'b0, 1'b0, w, n);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL chan_switch_drain: %0d bytes left, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int w, n;
        logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       prev_rdy;
        logic [7:0] prev_data;
        send_beat(8'h33, 8'h00, 1'b1, 1'b1, w, n);
        prev_rdy = 1'b1; prev_data = 8'h00;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            out_ready = (c < 4) ? pat[c] : 1'b1;
            @(negedge clk);
            if (!prev_rdy) begin
                n_checks += 2;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d]: got %b, expected 1", c, out_valid); end
                if (out_data !== prev_data) begin n_errors++; $display("FAIL stall_data[%0d]: got %02h, expected %02h", c, out_data, prev_data); end
            end
            prev_rdy = out_ready; prev_data = out_data;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL backpressure_drain: %0d bytes left valid %b, expected 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int w, n, sop_idx;
        bit ok;
        logic [7:0] first_byte;
`ifdef DMASTER_P2B_CHANNEL_EN
        sop_idx = 2; first_byte = 8'h7C;
`else
        sop_idx = 0; first_byte = 8'h7A;
`endif
        send_beat(8'h01, 8'h05, 1'b1, 1'b1, w, n);
        repeat (sop_idx) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_last_ch = 8'h00;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready); end
        if (out_data !== 8'h00) begin n_errors++; $display("FAIL midreset_data: got %02h, expected 00", out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_beat(8'h22, 8'h00, 1'b1, 1'b0, w, n);
        @(negedge clk);
        n_checks++;
        if (out_data !== first_byte) begin n_errors++; $display("FAIL midreset_first: got %02h, expected %02h", out_data, first_byte); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL midreset_drain: %0d bytes left, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sop_eop();
        test_midpacket();
        test_escape();
        test_channel_switch();
        test_backpressure();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
